// File: rtl/vend_sched.sv
// vend_sched: two-slot coin scheduler for a vending datapath.
// Each coin slot feeds a 2-deep FIFO. A round-robin FSM issues one coin at a
// time, waits for the datapath to settle, then dispenses and returns change.
// Optional statistics counters are enabled by defining VEND_SCHED_STATS_EN.
module vend_sched #(
  parameter int unsigned DISP_CYCLES   = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_a_coin,
  input  logic [1:0] i_b_coin,
  output logic       o_a_reject,
  output logic       o_b_reject,
  output logic       o_nickel,
  output logic       o_dime,
  output logic       o_quarter,
  input  logic       i_soda,
  input  logic [2:0] i_change,
  output logic       o_dispense,
  output logic       o_change_pulse,
  output logic       o_busy
`ifdef VEND_SCHED_STATS_EN
  ,
  output logic [7:0] o_coin_count,
  output logic [7:0] o_vend_count
`endif
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CODE_W  = 2;
  localparam int unsigned QCNT_W  = 2;
  localparam int unsigned CHG_W   = 3;
  localparam int unsigned NSLOT   = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_DISPENSE,
    S_CHANGE
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [CHG_W-1:0]    chg;
  logic                rr;      // 0 = slot A has priority, 1 = slot B

  logic [CODE_W-1:0]   q_mem  [NSLOT][2];
  logic [QCNT_W-1:0]   q_cnt  [NSLOT];
  logic [CODE_W-1:0]   coin_in[NSLOT];
  logic [NSLOT-1:0]    q_ne;
  logic [NSLOT-1:0]    pop;
  logic [NSLOT-1:0]    push;
  logic [NSLOT-1:0]    drop;
  logic [CODE_W-1:0]   head;
  logic                settle_last;
  logic                disp_last;

  // Grant arbitration, queue push/pop/drop decisions and phase-end flags
  always_comb begin
    coin_in[0] = i_a_coin;
    coin_in[1] = i_b_coin;
    for (int s = 0; s < NSLOT; s++) begin
      q_ne[s] = (q_cnt[s] != QCNT_W'(0));
    end
    pop[0] = (state == S_IDLE) && q_ne[0] && (!q_ne[1] || (rr == 1'b0));
    pop[1] = (state == S_IDLE) && q_ne[1] && (!q_ne[0] || (rr == 1'b1));
    for (int s = 0; s < NSLOT; s++) begin
      push[s] = (coin_in[s] != CODE_W'(0)) && ((q_cnt[s] != QCNT_W'(2)) || pop[s]);
      drop[s] = (coin_in[s] != CODE_W'(0)) && (q_cnt[s] == QCNT_W'(2)) && !pop[s];
    end
    head        = pop[0] ? q_mem[0][0] : q_mem[1][0];
    settle_last = (state == S_SETTLE)   && (cnt == CNT_W'(SETTLE_CYCLES - 1));
    disp_last   = (state == S_DISPENSE) && (cnt == CNT_W'(DISP_CYCLES - 1));
  end

  // Per-slot coin FIFOs; a pop and a push in the same cycle are both honoured
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int s = 0; s < NSLOT; s++) begin
        q_cnt[s]    <= '0;
        q_mem[s][0] <= '0;
        q_mem[s][1] <= '0;
      end
      o_a_reject <= 1'b0;
      o_b_reject <= 1'b0;
    end else begin
      for (int s = 0; s < NSLOT; s++) begin
        case ({push[s], pop[s]})
          2'b10: begin
            q_mem[s][q_cnt[s][0]] <= coin_in[s];
            q_cnt[s]              <= q_cnt[s] + QCNT_W'(1);
          end
          2'b01: begin
            q_mem[s][0] <= q_mem[s][1];
            q_cnt[s]    <= q_cnt[s] - QCNT_W'(1);
          end
          2'b11: begin
            if (q_cnt[s] == QCNT_W'(1)) begin
              q_mem[s][0] <= coin_in[s];
            end else begin
              q_mem[s][0] <= q_mem[s][1];
              q_mem[s][1] <= coin_in[s];
            end
          end
          default: ;
        endcase
      end
      o_a_reject <= drop[0];
      o_b_reject <= drop[1];
    end
  end

  // Vend sequencer: issue -> settle -> dispense -> change, all outputs registered
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      chg            <= '0;
      rr             <= 1'b0;
      o_nickel       <= 1'b0;
      o_dime         <= 1'b0;
      o_quarter      <= 1'b0;
      o_dispense     <= 1'b0;
      o_change_pulse <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      o_nickel  <= 1'b0;
      o_dime    <= 1'b0;
      o_quarter <= 1'b0;
      case (state)
        S_IDLE: begin
          o_dispense     <= 1'b0;
          o_change_pulse <= 1'b0;
          if (|pop) begin
            state     <= S_ISSUE;
            rr        <= pop[0];
            o_nickel  <= (head == 2'b01);
            o_dime    <= (head == 2'b10);
            o_quarter <= (head == 2'b11);
            o_busy    <= 1'b1;
          end else begin
            o_busy <= 1'b0;
          end
        end
        S_ISSUE: begin
          state <= S_SETTLE;
          cnt   <= '0;
        end
        S_SETTLE: begin
          if (settle_last) begin
            cnt <= '0;
            if (i_soda) begin
              chg        <= (i_change > 3'd4) ? 3'd4 : i_change;
              state      <= S_DISPENSE;
              o_dispense <= 1'b1;
            end else begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DISPENSE: begin
          if (disp_last) begin
            cnt        <= '0;
            o_dispense <= 1'b0;
            if (chg != CHG_W'(0)) begin
              state          <= S_CHANGE;
              o_change_pulse <= 1'b1;
            end else begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
            end
          end else begin
            cnt        <= cnt + CNT_W'(1);
            o_dispense <= 1'b1;
          end
        end
        S_CHANGE: begin
          // chg holds the pulses still owed including the one now high
          if (o_change_pulse) begin
            o_change_pulse <= 1'b0;
            if (chg == CHG_W'(1)) begin
              chg    <= '0;
              state  <= S_IDLE;
              o_busy <= 1'b0;
            end else begin
              chg <= chg - CHG_W'(1);
            end
          end else begin
            o_change_pulse <= 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef VEND_SCHED_STATS_EN
  // Issued-coin count saturates; vend count wraps
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_coin_count <= '0;
      o_vend_count <= '0;
    end else begin
      if ((state == S_ISSUE) && (o_coin_count != 8'hFF)) begin
        o_coin_count <= o_coin_count + 8'd1;
      end
      if (settle_last && i_soda) begin
        o_vend_count <= o_vend_count + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vend_sched.sv
// Self-checking bench for vend_sched: transaction-level reference model plus
// directed scenarios with literal timing expectations and randomized traffic.
module tb_vend_sched;

  localparam int S = 2;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] a_coin, b_coin;
  logic       soda;
  logic [2:0] change;
  logic       a_rej, b_rej, nickel, dime, quarter, dispense, chg_pulse, busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference model state: queues of coin codes and a position in the vend timeline
  int qa[$];
  int qb[$];
  int m_rr, m_k, m_end, m_code, m_n;
  bit m_act, m_rej_a, m_rej_b;

  // observation counters for directed scenarios
  int n_coin, n_disp, n_chg, n_rej_a, n_nickel;

  vend_sched #(.DISP_CYCLES(D), .SETTLE_CYCLES(S)) dut (
    .i_clk(clk), .i_rst(rst), .i_a_coin(a_coin), .i_b_coin(b_coin),
    .o_a_reject(a_rej), .o_b_reject(b_rej), .o_nickel(nickel), .o_dime(dime),
    .o_quarter(quarter), .i_soda(soda), .i_change(change),
    .o_dispense(dispense), .o_change_pulse(chg_pulse), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d want %0d", name, cyc, act, exp);
    end
  endtask

  function automatic void model_reset();
    qa.delete();
    qb.delete();
    m_rr = 0; m_k = 0; m_end = 0; m_code = 0; m_n = 0;
    m_act = 0; m_rej_a = 0; m_rej_b = 0;
  endfunction

  // Advance the model across one rising edge using the inputs present at that edge
  task automatic model_edge();
    bit pa;
    if (rst) begin
      model_reset();
      return;
    end
    pa = 0;
    if (m_act) begin
      if (m_k == S + 1) begin
        if (soda) begin
          m_n   = (change > 4) ? 4 : int'(change);
          m_end = S + 1 + D + ((m_n > 0) ? 2 * m_n - 1 : 0);
        end else begin
          m_end = S + 1;
        end
      end
      if (m_k == m_end) m_act = 0;
      else m_k++;
    end else if (qa.size() > 0 || qb.size() > 0) begin
      pa     = (qa.size() > 0) && (qb.size() == 0 || m_rr == 0);
      m_code = pa ? qa.pop_front() : qb.pop_front();
      m_rr   = pa ? 1 : 0;
      m_act  = 1;
      m_k    = 1;
      m_end  = S + 1;
    end
    m_rej_a = 0;
    m_rej_b = 0;
    if (a_coin != 0) begin
      if (qa.size() < 2) qa.push_back(int'(a_coin));
      else m_rej_a = 1;
    end
    if (b_coin != 0) begin
      if (qb.size() < 2) qb.push_back(int'(b_coin));
      else m_rej_b = 1;
    end
  endtask

  task automatic compare_all();
    int e_disp, e_chg;
    e_disp = (m_act && m_k >= S + 2 && m_k <= S + 1 + D) ? 1 : 0;
    e_chg  = (m_act && m_k >= S + 2 + D && ((m_k - (S + 2 + D)) % 2 == 0)) ? 1 : 0;
    chk("nickel",   nickel,    (m_act && m_k == 1 && m_code == 1) ? 1 : 0);
    chk("dime",     dime,      (m_act && m_k == 1 && m_code == 2) ? 1 : 0);
    chk("quarter",  quarter,   (m_act && m_k == 1 && m_code == 3) ? 1 : 0);
    chk("dispense", dispense,  e_disp);
    chk("change",   chg_pulse, e_chg);
    chk("busy",     busy,      m_act ? 1 : 0);
    chk("a_reject", a_rej,     m_rej_a ? 1 : 0);
    chk("b_reject", b_rej,     m_rej_b ? 1 : 0);
  endtask

  // One clock: model steps at the edge, outputs compared at the falling edge
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    compare_all();
    n_coin   += int'(nickel) + int'(dime) + int'(quarter);
    n_nickel += int'(nickel);
    n_disp   += int'(dispense);
    n_chg    += int'(chg_pulse);
    n_rej_a  += int'(a_rej);
  endtask

  task automatic clear_obs();
    n_coin = 0; n_disp = 0; n_chg = 0; n_rej_a = 0; n_nickel = 0;
  endtask

  // Assert reset asynchronously between edges, check outputs drop at once
  task automatic do_reset();
    a_coin = 0; b_coin = 0;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    cycle();
    cycle();
    rst = 1'b0;
    clear_obs();
  endtask

  initial begin
    rst = 1'b1;
    a_coin = 0; b_coin = 0; soda = 0; change = 0;
    #1;
    model_reset();
    compare_all();
    cycle();
    rst = 1'b0;
    clear_obs();

    // single quarter, no vend: pulse in cycle 2, idle again in cycle 3+S
    do_reset();
    soda = 0;
    a_coin = 2'b11;
    cycle();
    a_coin = 0;
    for (int t = 1; t <= S + 4; t++) begin
      chk("lit_quarter", quarter, (t == 2) ? 1 : 0);
      chk("lit_busy", busy, (t >= 2 && t <= 2 + S) ? 1 : 0);
      cycle();
    end

    // simultaneous dimes on A and B: two separate issue phases
    do_reset();
    a_coin = 2'b10; b_coin = 2'b10;
    cycle();
    a_coin = 0; b_coin = 0;
    for (int t = 1; t <= 2 * S + 8; t++) begin
      chk("lit_dime", dime, (t == 2 || t == S + 4) ? 1 : 0);
      cycle();
    end

    // vend with change 3: dispense D cycles then pulses 1,0,1,0,1
    do_reset();
    soda = 1; change = 3'd3;
    b_coin = 2'b01;
    cycle();
    b_coin = 0;
    for (int t = 1; t <= S + D + 10; t++) begin
      chk("lit_disp", dispense, (t >= S + 3 && t <= S + 2 + D) ? 1 : 0);
      chk("lit_chg", chg_pulse,
          (t == S + 3 + D || t == S + 5 + D || t == S + 7 + D) ? 1 : 0);
      chk("lit_busy_chg", busy, (t >= 2 && t <= S + D + 7) ? 1 : 0);
      cycle();
    end
    chk("lit_disp_count", n_disp, D);
    chk("lit_chg_count", n_chg, 3);
    soda = 0; change = 0;

    // three nickels on A during dispense: third is rejected, two are issued
    do_reset();
    soda = 1; change = 0;
    b_coin = 2'b11;
    cycle();
    b_coin = 0;
    for (int t = 1; t < S + 3; t++) cycle();
    soda = 0;
    for (int i = 0; i < 3; i++) begin
      a_coin = 2'b01;
      cycle();
    end
    a_coin = 0;
    for (int i = 0; i < 40; i++) cycle();
    chk("lit_rej_count", n_rej_a, 1);
    chk("lit_nickel_count", n_nickel, 2);

    // reset in dispense cycle 2 with a coin still queued, then clamped change
    do_reset();
    soda = 1; change = 0;
    a_coin = 2'b10;
    cycle();
    a_coin = 0;
    b_coin = 2'b01;
    cycle();
    b_coin = 0;
    for (int t = 2; t < S + 4; t++) cycle();
    chk("lit_disp_pre_rst", dispense, 1);
    rst = 1'b1;
    #1;
    model_reset();
    chk("lit_disp_in_rst", dispense, 0);
    chk("lit_busy_in_rst", busy, 0);
    compare_all();
    cycle();
    rst = 1'b0;
    clear_obs();
    for (int i = 0; i < 12; i++) cycle();
    chk("lit_queue_empty", n_coin, 0);
    soda = 1; change = 3'd6;
    a_coin = 2'b01;
    cycle();
    a_coin = 0;
    for (int i = 0; i < 30; i++) cycle();
    chk("lit_clamp_count", n_chg, 4);

    // randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 4000; i++) begin
      a_coin = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      b_coin = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      soda   = 1'($urandom_range(0, 1));
      change = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        cycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
